fifo_mux_n: RTL and testbench
=============================

# fifo_mux_n

Parametrised N-channel stream multiplexer with burst selection, successor to the two-input `fifo_mux2`. A select stream names a source channel and a beat count. The block forwards exactly that many valid/ready beats from the named channel to one registered output, then accepts the next select. It sits between the per-layer FIFOs and the shared backpropagation datapath, arbitrating under sequencer control.

## Interface
- `CHANNELS`, 4: number of input streams (≥2).
- `WIDTH`, 32: data width per stream.
- `COUNT_WIDTH`, 8: width of burst-length field.
- `SEL_WIDTH`, derived as clog2(CHANNELS): local, not overridable.

Ports:
- `clk`  in  1  sole clock; all state on its rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = in reset).
- `in_data`  in  CHANNELS*WIDTH  channel i occupies [i*WIDTH +: WIDTH].
- `in_valid`  in  CHANNELS  per-channel valid.
- `in_ready`  out  CHANNELS  per-channel ready; at most one bit set.
- `select`  in  SEL_WIDTH  source channel index.
- `select_count`  in  COUNT_WIDTH  burst length minus one (0 = one beat).
- `select_valid`  in  1  select stream valid.
- `select_ready`  out  1  select stream ready.
- `sel_error`  out  1  one-cycle pulse: select index ≥ CHANNELS was dropped.
- `result`  out  WIDTH  output data.
- `result_channel`  out  SEL_WIDTH  source channel of current `result`.
- `result_last`  out  1  current beat is final beat of its burst.
- `result_valid`  out  1  output valid.
- `result_ready`  in  1  output ready.
- `busy`  out  1  burst in progress (state ROUTE).

## Operation
- FSM states: IDLE, ROUTE. Reset state is IDLE.
- IDLE: `select_ready`=1 (0 while `rst`=0). All `in_ready`=0.
- IDLE, on select handshake with `select` < CHANNELS: latch channel into `ch_q` and `select_count` into `remaining`, then go to ROUTE.
- IDLE, on select handshake with `select` ≥ CHANNELS: consume the select and pulse `sel_error` next cycle. Stay in IDLE.
- ROUTE: `select_ready`=0, `busy`=1. `in_ready[ch_q]` = out_free, where out_free = !result_valid || result_ready. Other `in_ready` bits are 0.
- ROUTE, on input handshake: load the output register with `in_data[ch_q]`, `ch_q`, and last = (`remaining`==0).
  - If `remaining`==0, go to IDLE.
  - Otherwise decrement `remaining`.
- Output register: a single-stage pipe register. `result_valid` sets on load and clears on output handshake when no simultaneous load occurs. Load and drain in the same cycle is legal, giving one beat per cycle.
- Non-selected channels: `in_valid` is ignored and their data stays upstream, untouched.
- Select arriving while in ROUTE: held off by `select_ready`=0; the select waits upstream.
- Maximum burst is 2^COUNT_WIDTH beats. `remaining` never wraps because the transition at 0 ends the burst.

## Timing
- Reset values: `result`=0, `result_channel`=0, `result_last`=0, `result_valid`=0, `sel_error`=0, `busy`=0, `in_ready`=0, `select_ready`=0 while asserted.
- Reset mid-burst: the burst is abandoned, the registered beat is lost, and the FSM returns to IDLE immediately (asynchronous).
- Select handshake at cycle t → `in_ready[ch]` high at t+1 at the earliest.
- Input handshake at t → `result_valid` high at t+1.
- Steady state with `result_ready`=1 and source valid: 1 beat/cycle.
- Inter-burst gap: final-beat input handshake at t → `select_ready` at t+1 → next burst's first `in_ready` at t+2. This is one bubble per burst.
- Backpressure: with `result_valid`=1 and `result_ready`=0, `in_ready` is all-zero in the same cycle (combinational from the output register state, no input-to-ready path).
- `select_ready` depends only on the state register. No `in_valid`→`in_ready` combinational path.

## Structure
- Shared package `fifo_mux_pkg` holds:
  - the clog2 constant function;
  - FSM state encodings (IDLE=0, ROUTE=1);
  - the default CHANNELS/WIDTH/COUNT_WIDTH constants reused by the sequencer.
- Sub-module `pipe_reg`: single-entry valid/ready register, parameterised by width. It carries {channel, last, data}. Its reset is asynchronous active-low.

## Test plan
All cases use CHANNELS=4, WIDTH=32, COUNT_WIDTH=8.
- Reset check: hold `rst`=0 with all valids high → all outputs at reset values; release → `select_ready`=1, `in_ready`=0000.
- Single beat: channel 2 holds 0x64 valid; select=2, count=0; `result_ready`=1 → one beat `result`=0x64, `result_channel`=2, `result_last`=1; then IDLE.
- Burst: channel 1 streams 0x100..0x103; select=1, count=3, `result_ready`=1 → four consecutive beats with `result_last` only on 0x103.
  - Channels 0, 2, 3 valid throughout and never readied.
- Backpressure: same burst with `result_ready` toggling 1,0,0,1,… → no beat lost or duplicated; `in_ready[1]`=0 whenever the output is full and stalled.
- Illegal index: select=5 is unrepresentable at SEL_WIDTH=2, so rerun with CHANNELS=3 and select=3 → `sel_error` pulses once, no `in_ready`, FSM stays IDLE.
- Reset mid-burst: select=0, count=7; assert `rst` after 3 beats → `result_valid` drops asynchronously; after release, a new select=3, count=0 delivers channel 3 data correctly.

Source files
------------

// File: rtl/fifo_mux_pkg.sv
// ============================================================================
// Module  : fifo_mux_pkg
// Purpose : Shared constants, FSM encodings and clog2 helper for fifo_mux_n
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_mux_pkg;

   localparam int DEF_CHANNELS    = 4;
   localparam int DEF_WIDTH       = 32;
   localparam int DEF_COUNT_WIDTH = 8;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ROUTE = 1'b1;

   // Ceiling log2. Callers require value >= 2, so the result is at least 1.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mux_pipe_reg.sv
// ============================================================================
// Module  : pipe_reg
// Purpose : Single-entry valid/ready register; load and drain may share a cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);

   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             load;

   assign in_ready_o  = !valid_q || out_ready_i;
   assign load        = in_valid_i && in_ready_o;
   assign out_data_o  = data_q;
   assign out_valid_o = valid_q;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         data_q  <= in_data_i;
         valid_q <= 1'b1;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fifo_mux_n.sv
// ============================================================================
// Module  : fifo_mux_n
// Purpose : N-channel burst stream multiplexer driven by a select/count stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_mux_n
   import fifo_mux_pkg::*;
#(
   parameter int  CHANNELS    = DEF_CHANNELS,
   parameter int  WIDTH       = DEF_WIDTH,
   parameter int  COUNT_WIDTH = DEF_COUNT_WIDTH,
   localparam int SEL_WIDTH   = clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_WIDTH-1:0]      select,
   input  logic [COUNT_WIDTH-1:0]    select_count,
   input  logic                      select_valid,
   output logic                      select_ready,
   output logic                      sel_error,
   output logic [WIDTH-1:0]          result,
   output logic [SEL_WIDTH-1:0]      result_channel,
   output logic                      result_last,
   output logic                      result_valid,
   input  logic                      result_ready,
   output logic                      busy
);

   localparam int PAYLOAD_W = SEL_WIDTH + 1 + WIDTH;

   logic [0:0]             state_q, state_d;
   logic [SEL_WIDTH-1:0]   ch_q, ch_d;
   logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
   logic                   sel_error_q, sel_error_d;

   logic                   sel_legal;
   logic                   sel_hs;
   logic                   in_hs;
   logic                   out_free;
   logic [WIDTH-1:0]       ch_data [CHANNELS];
   logic [PAYLOAD_W-1:0]   load_payload;
   logic [PAYLOAD_W-1:0]   out_payload;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   // A power-of-two channel count makes every select encoding legal.
   if ((1 << SEL_WIDTH) == CHANNELS) begin : g_sel_full
      assign sel_legal = 1'b1;
   end else begin : g_sel_range
      assign sel_legal = int'(select) < CHANNELS;
   end

   assign select_ready = (state_q == ST_IDLE) && rst;
   assign busy         = (state_q == ST_ROUTE);
   assign sel_error    = sel_error_q;
   assign sel_hs       = select_valid && select_ready;
   assign in_hs        = (state_q == ST_ROUTE) && in_valid[ch_q] && out_free;

   always_comb begin
      in_ready = '0;
      if (state_q == ST_ROUTE) begin
         in_ready[ch_q] = out_free;
      end
   end

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      remaining_d = remaining_q;
      sel_error_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_hs) begin
               if (sel_legal) begin
                  ch_d        = select;
                  remaining_d = select_count;
                  state_d     = ST_ROUTE;
               end else begin
                  sel_error_d = 1'b1;
               end
            end
         end
         default: begin
            if (in_hs) begin
               if (remaining_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  remaining_d = remaining_q - COUNT_WIDTH'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         ch_q        <= '0;
         remaining_q <= '0;
         sel_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         remaining_q <= remaining_d;
         sel_error_q <= sel_error_d;
      end
   end

   assign load_payload = {ch_q, (remaining_q == '0), ch_data[ch_q]};

   pipe_reg #(
      .WIDTH (PAYLOAD_W)
   ) u_out_reg (
      .clk         (clk),
      .rst_ni      (rst),
      .in_data_i   (load_payload),
      .in_valid_i  (in_hs),
      .in_ready_o  (out_free),
      .out_data_o  (out_payload),
      .out_valid_o (result_valid),
      .out_ready_i (result_ready)
   );

   assign result         = out_payload[WIDTH-1:0];
   assign result_last    = out_payload[WIDTH];
   assign result_channel = out_payload[PAYLOAD_W-1 -: SEL_WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_fifo_mux_n.sv
// ============================================================================
// Module  : tb_fifo_mux_n
// Purpose : Directed self-checking bench for fifo_mux_n (4- and 3-channel)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_mux_n;

   localparam int CH = 4;
   localparam int W  = 32;
   localparam int CW = 8;
   localparam int SW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [CH*W-1:0] in_data;
   logic [CH-1:0]   in_valid;
   logic [CH-1:0]   in_ready;
   logic [SW-1:0]   select;
   logic [CW-1:0]   select_count;
   logic            select_valid, select_ready, sel_error;
   logic [W-1:0]    result;
   logic [SW-1:0]   result_channel;
   logic            result_last, result_valid, result_ready, busy;

   logic [3*W-1:0]  in_data3;
   logic [2:0]      in_valid3;
   logic [2:0]      in_ready3;
   logic [SW-1:0]   select3;
   logic [CW-1:0]   select_count3;
   logic            select_valid3, select_ready3, sel_error3;
   logic [W-1:0]    result3;
   logic [SW-1:0]   result_channel3;
   logic            result_last3, result_valid3, result_ready3, busy3;

   int checks = 0;
   int errors = 0;

   fifo_mux_n #(.CHANNELS(CH), .WIDTH(W), .COUNT_WIDTH(CW)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .select(select), .select_count(select_count), .select_valid(select_valid),
      .select_ready(select_ready), .sel_error(sel_error), .result(result),
      .result_channel(result_channel), .result_last(result_last),
      .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
   );

   fifo_mux_n #(.CHANNELS(3), .WIDTH(W), .COUNT_WIDTH(CW)) u_dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .select(select3), .select_count(select_count3), .select_valid(select_valid3),
      .select_ready(select_ready3), .sel_error(sel_error3), .result(result3),
      .result_channel(result_channel3), .result_last(result_last3),
      .result_valid(result_valid3), .result_ready(result_ready3), .busy(busy3)
   );

   task automatic set_ch(input int c, input logic [W-1:0] d);
      in_data[c*W +: W] = d;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      in_valid = '1; select = 2'd1; select_count = 8'd0; select_valid = 1'b1; result_ready = 1'b1;
      for (int c = 0; c < CH; c++) set_ch(c, 32'hA0 + 32'(c));
      in_data3 = '0; in_valid3 = '1; select3 = 2'd0; select_count3 = 8'd0;
      select_valid3 = 1'b1; result_ready3 = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
      checks++; if (result_channel !== 2'd0) begin errors++; $display("FAIL reset_channel got %0d exp 0", result_channel); end
      checks++; if (result_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", result_last); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", result_valid); end
      checks++; if (sel_error !== 1'b0) begin errors++; $display("FAIL reset_sel_error got %b exp 0", sel_error); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
      checks++; if (select_ready !== 1'b0) begin errors++; $display("FAIL reset_select_ready got %b exp 0", select_ready); end
      rst = 1'b1; select_valid = 1'b0; select_valid3 = 1'b0; in_valid3 = '0;
      #1;
      checks++; if (select_ready !== 1'b1) begin errors++; $display("FAIL release_select_ready got %b exp 1", select_ready); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL release_in_ready got %b exp 0000", in_ready); end
      @(negedge clk);
      in_valid = '0;
   endtask

   task automatic test_single_beat();
      @(negedge clk);
      in_valid = 4'b0100; set_ch(2, 32'h64);
      select = 2'd2; select_count = 8'd0; select_valid = 1'b1; result_ready = 1'b1;
      @(negedge clk);
      select_valid = 1'b0;
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
      checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready got %b exp 0100", in_ready); end
      checks++; if (select_ready !== 1'b0) begin errors++; $display("FAIL single_select_ready got %b exp 0", select_ready); end
      @(negedge clk);
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", result_valid); end
      checks++; if (result !== 32'h64) begin errors++; $display("FAIL single_result got %h exp 64", result); end
      checks++; if (result_channel !== 2'd2) begin errors++; $display("FAIL single_channel got %0d exp 2", result_channel); end
      checks++; if (result_last !== 1'b1) begin errors++; $display("FAIL single_last got %b exp 1", result_last); end
      checks++; if (busy !== 1'b0 || select_ready !== 1'b1) begin
         errors++; $display("FAIL single_idle busy %b select_ready %b exp 0 1", busy, select_ready);
      end
      @(negedge clk);
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", result_valid); end
      in_valid = '0;
   endtask

   // Streams base+k from channel ch; all other channels stay valid and must never be readied.
   task automatic run_burst(input int ch, input int cnt, input logic [W-1:0] base, input bit stall);
      int src_idx = 0;
      int got = 0;
      int cyc = 0;
      logic [CH-1:0] mask;
      mask = CH'(1) << ch;
      @(negedge clk);
      in_valid = '1;
      for (int c = 0; c < CH; c++) set_ch(c, 32'hA0 + 32'(c));
      select = SW'(ch); select_count = CW'(cnt); select_valid = 1'b1; result_ready = 1'b1;
      @(negedge clk);
      select_valid = 1'b0;
      while (got <= cnt && cyc < 200) begin
         if (stall) result_ready = (cyc % 3 == 0);
         set_ch(ch, base + W'(src_idx));
         #1;
         checks++; if ((in_ready & ~mask) !== '0) begin
            errors++; $display("FAIL burst_other_ready got %b cyc %0d exp none", in_ready, cyc);
         end
         if (result_valid && !result_ready) begin
            checks++; if (in_ready !== '0) begin
               errors++; $display("FAIL burst_backpressure in_ready %b cyc %0d exp 0000", in_ready, cyc);
            end
         end
         if (result_valid && result_ready) begin
            checks++; if (result !== base + W'(got) || result_channel !== SW'(ch) ||
                          result_last !== (got == cnt)) begin
               errors++; $display("FAIL burst_beat%0d got %h ch %0d last %b exp %h ch %0d last %b",
                                  got, result, result_channel, result_last, base + W'(got), ch, got == cnt);
            end
            got++;
         end
         if (in_valid[ch] && in_ready[ch]) src_idx++;
         @(negedge clk);
         cyc++;
      end
      checks++; if (got != cnt + 1) begin errors++; $display("FAIL burst_count got %0d exp %0d", got, cnt + 1); end
      if (!stall) begin
         checks++; if (cyc != cnt + 2) begin errors++; $display("FAIL burst_rate cycles %0d exp %0d", cyc, cnt + 2); end
      end
      checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL burst_end valid %b busy %b exp 0 0", result_valid, busy);
      end
      in_valid = '0; result_ready = 1'b1;
   endtask

   task automatic test_burst();
      run_burst(1, 3, 32'h100, 1'b0);
   endtask

   task automatic test_backpressure();
      run_burst(1, 3, 32'h100, 1'b1);
   endtask

   task automatic test_illegal_index();
      @(negedge clk);
      select3 = 2'd3; select_count3 = 8'd0; select_valid3 = 1'b1; in_valid3 = '1; result_ready3 = 1'b1;
      #1;
      checks++; if (select_ready3 !== 1'b1) begin errors++; $display("FAIL illegal_select_ready got %b exp 1", select_ready3); end
      @(negedge clk);
      select_valid3 = 1'b0;
      checks++; if (sel_error3 !== 1'b1) begin errors++; $display("FAIL illegal_pulse got %b exp 1", sel_error3); end
      checks++; if (busy3 !== 1'b0 || in_ready3 !== 3'b000) begin
         errors++; $display("FAIL illegal_idle busy %b in_ready %b exp 0 000", busy3, in_ready3);
      end
      repeat (3) begin
         @(negedge clk);
         checks++; if (sel_error3 !== 1'b0 || busy3 !== 1'b0 || in_ready3 !== 3'b000 || result_valid3 !== 1'b0) begin
            errors++; $display("FAIL illegal_after sel_error %b busy %b in_ready %b valid %b exp 0 0 000 0",
                               sel_error3, busy3, in_ready3, result_valid3);
         end
      end
      in_valid3 = '0;
   endtask

   task automatic test_reset_mid_burst();
      int src_idx = 0;
      int got = 0;
      int cyc = 0;
      @(negedge clk);
      in_valid = '1; set_ch(0, 32'h200);
      select = 2'd0; select_count = 8'd7; select_valid = 1'b1; result_ready = 1'b1;
      @(negedge clk);
      select_valid = 1'b0;
      while (got < 3 && cyc < 50) begin
         set_ch(0, 32'h200 + W'(src_idx));
         #1;
         if (result_valid && result_ready) got++;
         if (in_valid[0] && in_ready[0]) src_idx++;
         @(negedge clk);
         cyc++;
      end
      checks++; if (result_valid !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL midrst_before valid %b busy %b exp 1 1", result_valid, busy);
      end
      #2 rst = 1'b0;
      #1;
      checks++; if (result_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 4'b0000) begin
         errors++; $display("FAIL midrst_async valid %b busy %b in_ready %b exp 0 0 0000", result_valid, busy, in_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      in_valid = 4'b1000; set_ch(3, 32'h333);
      select = 2'd3; select_count = 8'd0; select_valid = 1'b1;
      @(negedge clk);
      select_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL midrst_in_ready got %b exp 1000", in_ready); end
      @(negedge clk);
      checks++; if (result_valid !== 1'b1 || result !== 32'h333 || result_channel !== 2'd3 || result_last !== 1'b1) begin
         errors++; $display("FAIL midrst_beat valid %b data %h ch %0d last %b exp 1 333 3 1",
                            result_valid, result, result_channel, result_last);
      end
      @(negedge clk);
      checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_end valid %b busy %b exp 0 0", result_valid, busy);
      end
      in_valid = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_beat();
      test_burst();
      test_backpressure();
      test_illegal_index();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
